conv_loop_sched: RTL and testbench

Command-driven scheduler for the three-level convolution address loop (channel c, row y, column x). It accepts one job descriptor, walks c/y/x with x innermost, and streams one (weight address, input address) pair per cycle to the weight and input memories over a valid/ready handshake with backpressure. It pulses `done` after the final pair is accepted. It sits between the layer controller (command side) and the memory read ports (output side).

---
 rtl/conv_sched_pkg.sv | 20 ++
 rtl/sched_dim_cnt.sv | 36 +++
 rtl/conv_loop_sched.sv | 151 +++++++++++++++
 tb/tb_conv_loop_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared types and defaults for the convolution loop scheduler
package conv_sched_pkg;
    localparam int DEF_CW = 4;
    localparam int DEF_AW = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [DEF_CW-1:0] c_last;
        logic [DEF_CW-1:0] y_last;
        logic [DEF_CW-1:0] x_last;
        logic [DEF_AW-1:0] w_base;
        logic [DEF_AW-1:0] i_base;
        logic [DEF_AW-1:0] ystride;
        logic [DEF_AW-1:0] cstride;
    } sched_desc_t;
endpackage

// File: rtl/sched_dim_cnt.sv
// rtl/sched_dim_cnt.sv - one wrapping loop index, 0..last_val, stepping on demand
module sched_dim_cnt
    import conv_sched_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    input  logic [CW-1:0] last_val,
    output logic [CW-1:0] idx,
    output logic          at_last
);
    logic [CW-1:0] idx_q, idx_d;

    assign at_last = (idx_q == last_val);
    assign idx     = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (step) begin
            idx_d = at_last ? '0 : idx_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/conv_loop_sched.sv
// rtl/conv_loop_sched.sv - c/y/x convolution address walker streaming (weight, input) address pairs
module conv_loop_sched
    import conv_sched_pkg::*;
#(
    parameter int CW = DEF_CW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [CW-1:0] cmd_c_last,
    input  logic [CW-1:0] cmd_y_last,
    input  logic [CW-1:0] cmd_x_last,
    input  logic [AW-1:0] cmd_w_base,
    input  logic [AW-1:0] cmd_i_base,
    input  logic [AW-1:0] cmd_i_ystride,
    input  logic [AW-1:0] cmd_i_cstride,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_wa,
    output logic [AW-1:0] out_ia,
    output logic          out_last,
    output logic          done,
    output logic          busy
);
    sched_state_t  state_q, state_d;
    logic [CW-1:0] c_last_q, c_last_d, y_last_q, y_last_d, x_last_q, x_last_d;
    logic [AW-1:0] ystride_q, ystride_d, cstride_q, cstride_d;
    logic [AW-1:0] row_q, row_d, chan_q, chan_d, wa_q, wa_d, ia_q, ia_d;
    logic          valid_q, valid_d, done_q, done_d;
    logic [CW-1:0] c_idx, y_idx, x_idx;
    logic          c_at, y_at, x_at;
    logic          accept, hs, final_pair, advance;

    assign accept     = cmd_valid && (state_q == ST_IDLE);
    assign hs         = valid_q && out_ready;
    assign final_pair = x_at && y_at && c_at;
    assign advance    = (state_q == ST_RUN) && hs && !final_pair && !abort;

    sched_dim_cnt #(.CW(CW)) u_x (
        .clk(clk), .rst(rst), .clr(accept), .step(advance),
        .last_val(x_last_q), .idx(x_idx), .at_last(x_at)
    );
    sched_dim_cnt #(.CW(CW)) u_y (
        .clk(clk), .rst(rst), .clr(accept), .step(advance && x_at),
        .last_val(y_last_q), .idx(y_idx), .at_last(y_at)
    );
    sched_dim_cnt #(.CW(CW)) u_c (
        .clk(clk), .rst(rst), .clr(accept), .step(advance && x_at && y_at),
        .last_val(c_last_q), .idx(c_idx), .at_last(c_at)
    );

    always_comb begin
        state_d   = state_q;
        c_last_d  = c_last_q;
        y_last_d  = y_last_q;
        x_last_d  = x_last_q;
        ystride_d = ystride_q;
        cstride_d = cstride_q;
        row_d     = row_q;
        chan_d    = chan_q;
        wa_d      = wa_q;
        ia_d      = ia_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d   = ST_RUN;
                    c_last_d  = cmd_c_last;
                    y_last_d  = cmd_y_last;
                    x_last_d  = cmd_x_last;
                    ystride_d = cmd_i_ystride;
                    cstride_d = cmd_i_cstride;
                    wa_d      = cmd_w_base;
                    ia_d      = cmd_i_base;
                    row_d     = cmd_i_base;
                    chan_d    = cmd_i_base;
                    valid_d   = 1'b1;
                end
            end
            ST_RUN: begin
                // abort takes priority even over the final handshake, so no done
                if (abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (hs && final_pair) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (advance) begin
                    wa_d = wa_q + AW'(1);
                    if (!x_at) begin
                        ia_d = ia_q + AW'(1);
                    end else if (!y_at) begin
                        ia_d  = row_q + ystride_q;
                        row_d = row_q + ystride_q;
                    end else begin
                        ia_d   = chan_q + cstride_q;
                        row_d  = chan_q + cstride_q;
                        chan_d = chan_q + cstride_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            c_last_q  <= '0;
            y_last_q  <= '0;
            x_last_q  <= '0;
            ystride_q <= '0;
            cstride_q <= '0;
            row_q     <= '0;
            chan_q    <= '0;
            wa_q      <= '0;
            ia_q      <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_last_q  <= c_last_d;
            y_last_q  <= y_last_d;
            x_last_q  <= x_last_d;
            ystride_q <= ystride_d;
            cstride_q <= cstride_d;
            row_q     <= row_d;
            chan_q    <= chan_d;
            wa_q      <= wa_d;
            ia_q      <= ia_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = valid_q;
    assign out_wa    = wa_q;
    assign out_ia    = ia_q;
    assign out_last  = valid_q && final_pair;
    assign done      = done_q;

    // Indices can never run past the bounds latched with the job.
    idx_in_range: assert property (@(posedge clk) disable iff (rst)
        (x_idx <= x_last_q) && (y_idx <= y_last_q) && (c_idx <= c_last_q));
endmodule

// File: tb/tb_conv_loop_sched.sv
// tb/tb_conv_loop_sched.sv - randomized self-checking bench for conv_loop_sched
module tb_conv_loop_sched;
    import conv_sched_pkg::*;

    localparam int CW = DEF_CW;
    localparam int AW = DEF_AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [CW-1:0] cmd_c_last, cmd_y_last, cmd_x_last;
    logic [AW-1:0] cmd_w_base, cmd_i_base, cmd_i_ystride, cmd_i_cstride;
    logic          abort, out_valid, out_ready, out_last, done, busy;
    logic [AW-1:0] out_wa, out_ia;

    int total = 0;
    int bad   = 0;

    conv_loop_sched #(.CW(CW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_c_last(cmd_c_last), .cmd_y_last(cmd_y_last), .cmd_x_last(cmd_x_last),
        .cmd_w_base(cmd_w_base), .cmd_i_base(cmd_i_base),
        .cmd_i_ystride(cmd_i_ystride), .cmd_i_cstride(cmd_i_cstride),
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .out_wa(out_wa), .out_ia(out_ia), .out_last(out_last),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic sched_desc_t mk(input int c, input int y, input int x,
                                       input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                                       input logic [AW-1:0] ys, input logic [AW-1:0] cs);
        sched_desc_t d;
        d.c_last = CW'(c);
        d.y_last = CW'(y);
        d.x_last = CW'(x);
        d.w_base = wb;
        d.i_base = ib;
        d.ystride = ys;
        d.cstride = cs;
        return d;
    endfunction

    task automatic scramble();
        cmd_c_last    = CW'($urandom);
        cmd_y_last    = CW'($urandom);
        cmd_x_last    = CW'($urandom);
        cmd_w_base    = $urandom;
        cmd_i_base    = $urandom;
        cmd_i_ystride = $urandom;
        cmd_i_cstride = $urandom;
    endtask

    // Starts and ends on a falling edge; ends in the done cycle when the job completes.
    task automatic run_job(input sched_desc_t d, input int pct, input int stall_at, input int abort_at);
        logic [AW-1:0] ewa[$];
        logic [AW-1:0] eia[$];
        int n, k, cyc, stall, budget;
        logic rdy, ab;
        bit aborted;
        for (int c = 0; c <= int'(d.c_last); c++)
            for (int y = 0; y <= int'(d.y_last); y++)
                for (int x = 0; x <= int'(d.x_last); x++) begin
                    ewa.push_back(d.w_base + AW'(ewa.size()));
                    eia.push_back(d.i_base + AW'(c) * d.cstride + AW'(y) * d.ystride + AW'(x));
                end
        n = ewa.size();
        chk("cmd_ready_before_job", cmd_ready, 1);
        cmd_c_last = d.c_last; cmd_y_last = d.y_last; cmd_x_last = d.x_last;
        cmd_w_base = d.w_base; cmd_i_base = d.i_base;
        cmd_i_ystride = d.ystride; cmd_i_cstride = d.cstride;
        cmd_valid = 1'b1; out_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        k = 0; cyc = 0; stall = 0; aborted = 0; budget = 4 * n + 20;
        while (k < n && !aborted && cyc < budget) begin
            if (k == stall_at && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = ($urandom_range(99) < pct);
            end
            ab = (k == abort_at);
            out_ready = rdy;
            abort = ab;
            cmd_valid = 1'($urandom_range(1));
            scramble();
            chk("out_valid", out_valid, 1);
            chk("out_wa", out_wa, ewa[k]);
            chk("out_ia", out_ia, eia[k]);
            chk("out_last", out_last, (k == n - 1));
            chk("busy_run", busy, 1);
            chk("cmd_ready_run", cmd_ready, 0);
            chk("done_run", done, 0);
            @(negedge clk);
            cyc++;
            if (ab) aborted = 1;
            else if (rdy) k++;
        end
        cmd_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        if (aborted) begin
            chk("abort_valid", out_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_cmd_ready", cmd_ready, 1);
            @(negedge clk);
            chk("abort_done_late", done, 0);
        end else if (k == n) begin
            chk("done_pulse", done, 1);
            chk("done_cmd_ready", cmd_ready, 1);
            chk("done_valid", out_valid, 0);
            chk("done_busy", busy, 0);
        end else begin
            chk("job_timeout", k, n);
        end
    endtask

    initial begin
        sched_desc_t d;
        int n, ab_at;
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_wa", out_wa, 0);
        chk("rst_out_ia", out_ia, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_cmd_ready", cmd_ready, 1);
        chk("idle_abort_valid", out_valid, 0);
        chk("idle_abort_busy", busy, 0);

        d = mk(2, 2, 2, 0, 0, 10, 100);
        run_job(d, 100, -1, -1);
        @(negedge clk);
        run_job(d, 100, 3, -1);
        // next job accepted in the done cycle
        run_job(mk(0, 0, 0, 32'h40, 32'h80, 7, 9), 100, -1, -1);
        run_job(mk(0, 0, 3, 32'hFFFF_FFFE, 32'h1000, 5, 5), 100, -1, -1);
        @(negedge clk);
        run_job(d, 100, -1, 4);
        run_job(mk(1, 1, 2, 32'h500, 32'h2000, 16, 256), 70, -1, -1);
        @(negedge clk);
        run_job(mk(0, 1, 1, 32'h10, 32'h20, 3, 4), 100, -1, 3);

        cmd_c_last = 2; cmd_y_last = 2; cmd_x_last = 2;
        cmd_w_base = 32'h77; cmd_i_base = 32'h99; cmd_i_ystride = 10; cmd_i_cstride = 100;
        cmd_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_wa", out_wa, 0);
        chk("midrst_ia", out_ia, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        chk("midrst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        chk("midrst_no_done", done, 0);
        run_job(mk(1, 0, 1, 32'h300, 32'h400, 8, 64), 100, -1, -1);

        for (int j = 0; j < 10; j++) begin
            d = mk($urandom_range(3), $urandom_range(3), $urandom_range(3),
                   $urandom, $urandom, $urandom, $urandom);
            n = (int'(d.c_last) + 1) * (int'(d.y_last) + 1) * (int'(d.x_last) + 1);
            ab_at = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
            run_job(d, 40 + int'($urandom_range(60)), int'($urandom_range(n)), ab_at);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
